aq_djpeg_idct_inbuf: RTL and testbench
======================================

# aq_djpeg_idct_inbuf

Double-banked 8x8 coefficient buffer feeding the IDCT input port. It accepts dequantized coefficients from the Huffman/dequantizer stage in zigzag order, converts them to natural (row-major) order, and zero-fills unwritten positions. It presents each completed block to the IDCT as 32 address pairs: natural index `a` and natural index `a+32`. Two banks allow one block to be filled while the IDCT reads the other.

## Interface
- No parameters; widths are fixed by the JPEG decoder datapath.
- `clk`  in  1  — single clock, all logic rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `ProcessInit`  in  1  — synchronous clear of both banks at frame start.
- `HmEnable`  in  1  — coefficient write strobe.
- `HmAddress`  in  6  — zigzag index 0..63.
- `HmData`  in  16  — signed dequantized coefficient.
- `HmEnd`  in  1  — block complete; may coincide with the last `HmEnable`.
- `HmReady`  out  1  — write bank can accept data.
- `DataOutEnable`  out  1  — a full block is available; drives IDCT `DataInEnable`.
- `DataOutRead`  in  1  — single-cycle release pulse from the IDCT: block fully fetched.
- `DataOutAddress`  in  5  — pair address 0..31.
- `DataOutA`  out  16  — coefficient at natural index `DataOutAddress`.
- `DataOutB`  out  16  — coefficient at natural index `DataOutAddress+32`.

## Operation
- Each bank is in one of three states: EMPTY, FILL, or FULL.
  - EMPTY→FILL on the first accepted write.
  - EMPTY or FILL→FULL on `HmEnd`.
  - FULL→EMPTY on `DataOutRead` while that bank is the read bank.
- `wbank` and `rbank` are 1-bit pointers.
  - `wbank` toggles when its bank goes FULL.
  - `rbank` toggles on release.
- A write is accepted when `HmEnable && HmReady`.
  - The natural index is `zz2nat(HmAddress)`.
  - Index bit 5 selects the high or low RAM half; bits 4:0 give the address within the half.
  - The valid bit for that index is set.
  - Writes while `!HmReady` are dropped.
  - A repeated index overwrites: last write wins.
- `HmEnd` with no preceding writes produces an all-zero FULL block.
- `HmEnd` while `!HmReady` is ignored.
- Read data is `valid[idx] ? ram[idx] : 16'h0000` for both halves.
- Release clears all 64 valid bits of the released bank in one cycle. RAM contents are not cleared.
- `DataOutRead` while `!DataOutEnable` is ignored.
- `ProcessInit` sets both banks EMPTY, both pointers to 0, and clears all valid bits. It takes precedence over all same-cycle events.

## Timing
- Reset values: `HmReady`=1, `DataOutEnable`=0, `DataOutA`=`DataOutB`=0, banks EMPTY, pointers 0.
- Read latency is 1 cycle: address presented at cycle t, data registered and valid at t+1.
  - Reading continuously gives full throughput.
  - `DataOutA`/`DataOutB` hold their value when the address is unchanged.
- `HmEnd` at t:
  - Bank FULL at t+1.
  - `DataOutEnable`=1 at t+1 if it is the read bank.
  - `HmReady` at t+1 reflects the next bank.
- `HmReady` = (bank[wbank] != FULL), registered. It falls one cycle after the second bank fills.
- `DataOutRead` at t:
  - Bank EMPTY at t+1.
  - `DataOutEnable` at t+1 reflects the other bank.
  - `HmReady` rises at t+1 if the writer was stalled.
- `HmEnd` and `DataOutRead` in the same cycle on different banks are both honored.
  - With both banks FULL and the writer stalled, a release at t allows writes from t+1.
- A write and `HmEnd` in the same cycle: the write lands in the closing bank.
- Asynchronous reset mid-block discards all data. No partial block is output.

## Structure
- Shared package `aq_djpeg_pkg` holds:
  - bank state encodings (EMPTY=2'd0, FILL=2'd1, FULL=2'd2);
  - `COEF_W`=16;
  - the 64-entry zigzag-to-natural table.
- Sub-module `aq_djpeg_zigzag`: combinational 6→6 ROM, `zz2nat`. Examples: 0→0, 1→1, 2→8, 3→16, 4→9, 5→2, 63→63.
- Storage: per bank, two 32x16 synchronous RAMs (low half and high half) and a 64-bit valid register.

## Test plan
- Write zigzag 0 = 0x0040 and zigzag 2 = 0xFFF0, then `HmEnd`; read addr 0 → A=0x0040, B=0; addr 8 → A=0xFFF0, B=0; all others 0.
- Write zigzag 63 = 0x1234, then `HmEnd`; addr 31 → A=0, B=0x1234, one cycle after the address is presented.
- Fill two blocks with no release → `HmReady`=0; further writes dropped; `DataOutRead` → `HmReady`=1 next cycle, `DataOutEnable` stays 1 (second bank), second block's data returned.
- `HmEnd` with zero writes → `DataOutEnable`=1; all 32 addresses return A=B=0.
- Write zigzag 1 twice (0x0001 then 0x0002) → addr 1 A=0x0002; after release and refill without index 1, addr 1 A=0 (valid cleared).
- `ProcessInit` asserted with both banks FULL and concurrent `HmEnable`/`DataOutRead` → next cycle `DataOutEnable`=0, `HmReady`=1, subsequent reads return 0.

Source files
------------

// File: rtl/aq_djpeg_pkg.sv
// ---------------------------------------------------------------------------
// aq_djpeg_pkg
//
// Shared definitions for the JPEG decoder IDCT input buffer:
//   - bank_state_t : occupancy state of one coefficient bank
//   - COEF_W       : width of a dequantized coefficient
//   - ZZ2NAT       : zigzag scan index -> natural (row-major) index table
// No ports; imported by the buffer and the zigzag ROM.
// ---------------------------------------------------------------------------
package aq_djpeg_pkg;

    localparam int COEF_W = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_t;

    // Entry k holds the row*8+col position of the k-th coefficient in zigzag order.
    localparam logic [5:0] ZZ2NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/aq_djpeg_zigzag.sv
// ---------------------------------------------------------------------------
// aq_djpeg_zigzag
//
// Combinational 64-entry ROM converting a zigzag scan index into the
// natural (row-major) index inside an 8x8 block.
//   zz_idx  in  6 : zigzag index 0..63
//   nat_idx out 6 : natural index 0..63
// ---------------------------------------------------------------------------
module aq_djpeg_zigzag
    import aq_djpeg_pkg::*;
(
    input  logic [5:0] zz_idx,
    output logic [5:0] nat_idx
);

    assign nat_idx = ZZ2NAT[zz_idx];

endmodule

// File: rtl/aq_djpeg_idct_inbuf.sv
// ---------------------------------------------------------------------------
// aq_djpeg_idct_inbuf
//
// Double-banked 8x8 coefficient buffer in front of the IDCT. The dequantizer
// writes coefficients in zigzag order into the write bank; they are stored
// in natural order, and positions never written read back as zero. The IDCT
// fetches a completed block as 32 pairs (index a, index a+32) from the read
// bank while the next block fills the other bank.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ProcessInit     : synchronous clear of both banks (frame start)
//   HmEnable        : coefficient write strobe
//   HmAddress[5:0]  : zigzag index of the coefficient
//   HmData[15:0]    : signed dequantized coefficient
//   HmEnd           : block complete (may coincide with the last write)
//   HmReady         : write bank can accept data
//   DataOutEnable   : a full block is available to the IDCT
//   DataOutRead     : IDCT release pulse, current read block fully fetched
//   DataOutAddress  : pair address 0..31
//   DataOutA/B      : coefficients at natural index addr / addr+32 (1-cycle latency)
// ---------------------------------------------------------------------------
module aq_djpeg_idct_inbuf
    import aq_djpeg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ProcessInit,
    input  logic        HmEnable,
    input  logic [5:0]  HmAddress,
    input  logic [15:0] HmData,
    input  logic        HmEnd,
    output logic        HmReady,
    output logic        DataOutEnable,
    input  logic        DataOutRead,
    input  logic [4:0]  DataOutAddress,
    output logic [15:0] DataOutA,
    output logic [15:0] DataOutB
);

    // Bank bookkeeping
    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wbank_q, wbank_d;
    logic        rbank_q, rbank_d;
    logic [63:0] valid_q [2];
    logic [63:0] valid_d [2];
    logic        hm_ready_q, hm_ready_d;
    logic        out_en_q, out_en_d;

    // Coefficient storage: low half holds natural indices 0..31, high half 32..63
    logic [COEF_W-1:0] ram_lo [2][32];
    logic [COEF_W-1:0] ram_hi [2][32];
    logic [COEF_W-1:0] rd_a_q, rd_b_q;
    logic              vld_a_q, vld_a_d;
    logic              vld_b_q, vld_b_d;

    logic [5:0] nat_idx;
    logic       wr_acc;
    logic       end_acc;
    logic       rel_acc;

    aq_djpeg_zigzag u_zigzag (
        .zz_idx  (HmAddress),
        .nat_idx (nat_idx)
    );

    // HmReady and DataOutEnable are registered copies of the bank state of
    // the current write/read bank, so they can qualify the strobes directly.
    // ProcessInit also suppresses the RAM write so a clear cycle stores nothing.
    assign wr_acc  = HmEnable & hm_ready_q & ~ProcessInit;
    assign end_acc = HmEnd & hm_ready_q;
    assign rel_acc = DataOutRead & out_en_q;

    // Next-state logic for the banks. A write accepted in the same cycle as
    // HmEnd lands in the bank being closed because both use wbank_q. End and
    // release can never hit the same bank: end needs a non-full bank, release
    // needs a full one.
    always_comb begin
        bank_d  = bank_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        valid_d = valid_q;

        if (ProcessInit) begin
            bank_d[0]  = BANK_EMPTY;
            bank_d[1]  = BANK_EMPTY;
            wbank_d    = 1'b0;
            rbank_d    = 1'b0;
            valid_d[0] = '0;
            valid_d[1] = '0;
        end else begin
            if (wr_acc) begin
                valid_d[wbank_q][nat_idx] = 1'b1;
                if (bank_q[wbank_q] == BANK_EMPTY) begin
                    bank_d[wbank_q] = BANK_FILL;
                end
            end
            if (end_acc) begin
                bank_d[wbank_q] = BANK_FULL;
                wbank_d         = ~wbank_q;
            end
            if (rel_acc) begin
                bank_d[rbank_q]  = BANK_EMPTY;
                valid_d[rbank_q] = '0;
                rbank_d          = ~rbank_q;
            end
        end

        // Flags follow the bank each pointer will select next cycle
        hm_ready_d = (bank_d[wbank_d] != BANK_FULL);
        out_en_d   = (bank_d[rbank_d] == BANK_FULL);

        vld_a_d = valid_q[rbank_q][{1'b0, DataOutAddress}];
        vld_b_d = valid_q[rbank_q][{1'b1, DataOutAddress}];
    end

    // Control and valid-tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]  <= BANK_EMPTY;
            bank_q[1]  <= BANK_EMPTY;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            hm_ready_q <= 1'b1;
            out_en_q   <= 1'b0;
            vld_a_q    <= 1'b0;
            vld_b_q    <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            valid_q    <= valid_d;
            hm_ready_q <= hm_ready_d;
            out_en_q   <= out_en_d;
            vld_a_q    <= vld_a_d;
            vld_b_q    <= vld_b_d;
        end
    end

    // Synchronous RAMs: no reset, so they map onto block memory. Stale
    // contents are harmless because the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (nat_idx[5]) begin
                ram_hi[wbank_q][nat_idx[4:0]] <= HmData;
            end else begin
                ram_lo[wbank_q][nat_idx[4:0]] <= HmData;
            end
        end
        rd_a_q <= ram_lo[rbank_q][DataOutAddress];
        rd_b_q <= ram_hi[rbank_q][DataOutAddress];
    end

    // Unwritten positions read as zero; the valid flags are reset, so the
    // outputs are zero out of reset even though the RAM data is not.
    assign DataOutA      = vld_a_q ? rd_a_q : '0;
    assign DataOutB      = vld_b_q ? rd_b_q : '0;
    assign HmReady       = hm_ready_q;
    assign DataOutEnable = out_en_q;

endmodule

// File: tb/tb_aq_djpeg_idct_inbuf.sv
// ---------------------------------------------------------------------------
// tb_aq_djpeg_idct_inbuf
//
// Self-checking bench for the IDCT input buffer. Expected blocks are built in
// natural order from the zigzag writes the bench issues (zigzag order is
// generated by walking the 8x8 anti-diagonals). Each read address pushes its
// expected A/B pair to a scoreboard queue; the pair is popped and compared
// when the registered output appears one cycle later.
// ---------------------------------------------------------------------------
module tb_aq_djpeg_idct_inbuf;

    logic        clk = 1'b0;
    logic        rst;
    logic        ProcessInit;
    logic        HmEnable;
    logic [5:0]  HmAddress;
    logic [15:0] HmData;
    logic        HmEnd;
    logic        HmReady;
    logic        DataOutEnable;
    logic        DataOutRead;
    logic [4:0]  DataOutAddress;
    logic [15:0] DataOutA;
    logic [15:0] DataOutB;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [5:0]  zz_nat [64];
    logic [15:0] exp_blk [4][64];
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    aq_djpeg_idct_inbuf dut (
        .clk            (clk),
        .rst            (rst),
        .ProcessInit    (ProcessInit),
        .HmEnable       (HmEnable),
        .HmAddress      (HmAddress),
        .HmData         (HmData),
        .HmEnd          (HmEnd),
        .HmReady        (HmReady),
        .DataOutEnable  (DataOutEnable),
        .DataOutRead    (DataOutRead),
        .DataOutAddress (DataOutAddress),
        .DataOutA       (DataOutA),
        .DataOutB       (DataOutB)
    );

    // Zigzag order by walking anti-diagonals, alternating direction
    task automatic build_zigzag();
        int r;
        int c;
        r = 0;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            zz_nat[i] = 6'(r * 8 + c);
            if (((r + c) % 2) == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
    endtask

    task automatic blk_clear(input int s);
        for (int i = 0; i < 64; i++) exp_blk[s][i] = 16'h0000;
    endtask

    task automatic blk_put(input int s, input logic [5:0] zz, input logic [15:0] d);
        exp_blk[s][zz_nat[zz]] = d;
    endtask

    // All stimulus tasks start and end on a falling edge
    task automatic hm_write(input logic [5:0] zz, input logic [15:0] d, input logic last);
        HmEnable  = 1'b1;
        HmAddress = zz;
        HmData    = d;
        HmEnd     = last;
        @(negedge clk);
        HmEnable  = 1'b0;
        HmEnd     = 1'b0;
    endtask

    task automatic hm_end();
        HmEnd = 1'b1;
        @(negedge clk);
        HmEnd = 1'b0;
    endtask

    task automatic release_blk();
        DataOutRead = 1'b1;
        @(negedge clk);
        DataOutRead = 1'b0;
    endtask

    // Sweep all 32 pair addresses through the scoreboard
    task automatic read_block(input int s, input string tag);
        logic [31:0] want;
        for (int a = 0; a < 32; a++) begin
            DataOutAddress = a[4:0];
            sb_q.push_back({exp_blk[s][a], exp_blk[s][a + 32]});
            @(negedge clk);
            want = sb_q.pop_front();
            n_cmp++;
            if ({DataOutA, DataOutB} !== want) begin
                n_err++;
                $display("[TB] FAIL %s addr %0d: A/B got %h/%h expected %h/%h",
                         tag, a, DataOutA, DataOutB, want[31:16], want[15:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (HmReady !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %b expected 1", HmReady); end
        n_cmp++; if (DataOutEnable !== 1'b0) begin n_err++; $display("[TB] FAIL reset_outen: got %b expected 0", DataOutEnable); end
        n_cmp++; if (DataOutA !== 16'h0) begin n_err++; $display("[TB] FAIL reset_a: got %h expected 0000", DataOutA); end
        n_cmp++; if (DataOutB !== 16'h0) begin n_err++; $display("[TB] FAIL reset_b: got %h expected 0000", DataOutB); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        blk_clear(0);
        blk_put(0, 6'd0, 16'h0040);
        blk_put(0, 6'd2, 16'hFFF0);
        hm_write(6'd0, 16'h0040, 1'b0);
        hm_write(6'd2, 16'hFFF0, 1'b0);
        n_cmp++; if (DataOutEnable !== 1'b0) begin n_err++; $display("[TB] FAIL basic_outen_fill: got %b expected 0", DataOutEnable); end
        hm_end();
        n_cmp++; if (DataOutEnable !== 1'b1) begin n_err++; $display("[TB] FAIL basic_outen: got %b expected 1", DataOutEnable); end
        n_cmp++; if (HmReady !== 1'b1) begin n_err++; $display("[TB] FAIL basic_ready: got %b expected 1", HmReady); end
        read_block(0, "basic");
        release_blk();
        n_cmp++; if (DataOutEnable !== 1'b0) begin n_err++; $display("[TB] FAIL basic_release: got %b expected 0", DataOutEnable); end
    endtask

    task automatic test_last_index();
        blk_clear(1);
        blk_put(1, 6'd63, 16'h1234);
        hm_write(6'd63, 16'h1234, 1'b1);
        n_cmp++; if (DataOutEnable !== 1'b1) begin n_err++; $display("[TB] FAIL last_outen: got %b expected 1", DataOutEnable); end
        read_block(1, "last_index");
        @(negedge clk);
        n_cmp++; if (DataOutB !== 16'h1234) begin n_err++; $display("[TB] FAIL last_hold_b: got %h expected 1234", DataOutB); end
        n_cmp++; if (DataOutA !== 16'h0000) begin n_err++; $display("[TB] FAIL last_hold_a: got %h expected 0000", DataOutA); end
        release_blk();
    endtask

    task automatic test_back_to_back();
        blk_clear(0);
        blk_clear(1);
        blk_put(0, 6'd5, 16'h0555);
        hm_write(6'd5, 16'h0555, 1'b0);
        hm_end();
        n_cmp++; if (HmReady !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready_one: got %b expected 1", HmReady); end
        blk_put(1, 6'd10, 16'h0AAA);
        blk_put(1, 6'd0, 16'h7FFF);
        hm_write(6'd10, 16'h0AAA, 1'b0);
        hm_write(6'd0, 16'h7FFF, 1'b0);
        hm_end();
        n_cmp++; if (HmReady !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_ready_two: got %b expected 0", HmReady); end
        n_cmp++; if (DataOutEnable !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_outen: got %b expected 1", DataOutEnable); end
        // Write and end while stalled must both be dropped
        hm_write(6'd1, 16'h1111, 1'b1);
        n_cmp++; if (HmReady !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_stalled: got %b expected 0", HmReady); end
        read_block(0, "b2b_first");
        release_blk();
        n_cmp++; if (HmReady !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready_rel: got %b expected 1", HmReady); end
        n_cmp++; if (DataOutEnable !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_outen_rel: got %b expected 1", DataOutEnable); end
        read_block(1, "b2b_second");
        release_blk();
        n_cmp++; if (DataOutEnable !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_outen_end: got %b expected 0", DataOutEnable); end
    endtask

    task automatic test_empty_block();
        blk_clear(2);
        hm_end();
        n_cmp++; if (DataOutEnable !== 1'b1) begin n_err++; $display("[TB] FAIL empty_outen: got %b expected 1", DataOutEnable); end
        read_block(2, "empty");
        release_blk();
    endtask

    task automatic test_overwrite();
        blk_clear(0);
        blk_clear(1);
        blk_clear(2);
        blk_put(0, 6'd1, 16'h0002);
        hm_write(6'd1, 16'h0001, 1'b0);
        hm_write(6'd1, 16'h0002, 1'b0);
        hm_end();
        hm_end();
        read_block(0, "overwrite");
        release_blk();
        // Refill the released bank without index 1; its old RAM word must not reappear
        blk_put(2, 6'd0, 16'h0009);
        hm_write(6'd0, 16'h0009, 1'b0);
        hm_end();
        n_cmp++; if (HmReady !== 1'b0) begin n_err++; $display("[TB] FAIL ovw_ready: got %b expected 0", HmReady); end
        read_block(1, "ovw_empty");
        release_blk();
        read_block(2, "ovw_refill");
        release_blk();
    endtask

    task automatic test_process_init();
        hm_write(6'd3, 16'h0333, 1'b1);
        hm_write(6'd7, 16'h0777, 1'b1);
        n_cmp++; if (HmReady !== 1'b0) begin n_err++; $display("[TB] FAIL init_pre_ready: got %b expected 0", HmReady); end
        ProcessInit = 1'b1;
        HmEnable    = 1'b1;
        HmAddress   = 6'd4;
        HmData      = 16'h4444;
        HmEnd       = 1'b1;
        DataOutRead = 1'b1;
        @(negedge clk);
        ProcessInit = 1'b0;
        HmEnable    = 1'b0;
        HmEnd       = 1'b0;
        DataOutRead = 1'b0;
        n_cmp++; if (DataOutEnable !== 1'b0) begin n_err++; $display("[TB] FAIL init_outen: got %b expected 0", DataOutEnable); end
        n_cmp++; if (HmReady !== 1'b1) begin n_err++; $display("[TB] FAIL init_ready: got %b expected 1", HmReady); end
        blk_clear(3);
        read_block(3, "init_zero");
        blk_clear(0);
        blk_put(0, 6'd4, 16'h0044);
        hm_write(6'd4, 16'h0044, 1'b1);
        n_cmp++; if (DataOutEnable !== 1'b1) begin n_err++; $display("[TB] FAIL init_new_outen: got %b expected 1", DataOutEnable); end
        read_block(0, "init_new");
        release_blk();
    endtask

    task automatic test_async_reset();
        hm_write(6'd9, 16'h0999, 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (HmReady !== 1'b1) begin n_err++; $display("[TB] FAIL arst_ready: got %b expected 1", HmReady); end
        n_cmp++; if (DataOutEnable !== 1'b0) begin n_err++; $display("[TB] FAIL arst_outen: got %b expected 0", DataOutEnable); end
        blk_clear(3);
        hm_end();
        read_block(3, "arst_zero");
        release_blk();
    endtask

    initial begin
        rst            = 1'b1;
        ProcessInit    = 1'b0;
        HmEnable       = 1'b0;
        HmAddress      = 6'd0;
        HmData         = 16'h0;
        HmEnd          = 1'b0;
        DataOutRead    = 1'b0;
        DataOutAddress = 5'd0;
        build_zigzag();
        @(negedge clk);
        test_reset();
        test_basic();
        test_last_index();
        test_back_to_back();
        test_empty_block();
        test_overwrite();
        test_process_init();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
